// File: rtl/stk_pkg.sv
// stk_pkg: shared types and helpers for the stack engine.
//   opcode_t        command opcodes (PUSH, POP and, when STK_CTRL_PEEK_EN is
//                   defined, PEEK).
//   rsp_t           generic response container (error flag plus data).
//                   Its data field is sized for the widest supported stack.
//                   A consumer keeps only the low W bits.
//   is_legal_opcode returns 1 for opcodes the engine executes.
// Optional feature macro: STK_CTRL_PEEK_EN (adds OPCODE_PEEK = 2'b11).
package stk_pkg;

  localparam int STK_MAX_W = 64;

  typedef enum logic [1:0] {
    OPCODE_PUSH = 2'b01,
`ifdef STK_CTRL_PEEK_EN
    OPCODE_PEEK = 2'b11,
`endif
    OPCODE_POP  = 2'b10
  } opcode_t;

  typedef struct packed {
    logic                 err;
    logic [STK_MAX_W-1:0] dat;
  } rsp_t;

  function automatic logic is_legal_opcode(input opcode_t op);
    logic legal;
    case (op)
      OPCODE_PUSH: legal = 1'b1;
      OPCODE_POP:  legal = 1'b1;
`ifdef STK_CTRL_PEEK_EN
      OPCODE_PEEK: legal = 1'b1;
`endif
      default:     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/stk_ctrl_mem.sv
// stk_ctrl_mem: N x W flop array backing the stack.
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write index
//   wdat   in  write data
//   raddr  in  read index (combinational read)
//   rdat   out read data, mem[raddr]; 0 for an index past the last entry
// Contents are deliberately not reset.
module stk_ctrl_mem
  import stk_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 16,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdat,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdat
);

  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < N)) begin
      mem_q[waddr] <= wdat;
    end
  end

  // Non-power-of-two depths leave unused index codes; return 0 for those.
  assign rdat = (int'(raddr) < N) ? mem_q[raddr] : '0;

endmodule

// File: rtl/stk_ctrl.sv
// stk_ctrl: LIFO stack engine with valid/ready command and response sides.
//   clk         in  clock
//   arst        in  asynchronous reset, active-high
//   cmd_vld     in  command valid
//   cmd_opcode  in  stk_pkg::opcode_t encoding
//   cmd_dat     in  push data (ignored for other opcodes)
//   cmd_rdy     out command accepted when cmd_vld & cmd_rdy
//   rsp_vld     out response valid
//   rsp_dat     out popped/peeked data, 0 for push and errors
//   rsp_err     out overflow, underflow or illegal opcode
//   rsp_rdy     in  response consumed when rsp_vld & rsp_rdy
//   empty       out occupancy == 0
//   full        out occupancy == N
//   level       out current occupancy
// Optional feature macro: STK_CTRL_PEEK_EN (opcode 2'b11 reads top of stack
// without popping; otherwise 2'b11 is illegal).
// N must be at least 2.
module stk_ctrl
  import stk_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   cmd_vld,
  input  logic [1:0]             cmd_opcode,
  input  logic [W-1:0]           cmd_dat,
  output logic                   cmd_rdy,
  output logic                   rsp_vld,
  output logic [W-1:0]           rsp_dat,
  output logic                   rsp_err,
  input  logic                   rsp_rdy,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(N+1)-1:0] level
);

  localparam int LW = $clog2(N + 1);
  localparam int AW = $clog2(N);

  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic          rsp_err_q, rsp_err_d;
  logic [W-1:0]  rsp_dat_q, rsp_dat_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] mem_raddr;
  logic [W-1:0]  mem_rdat;

  logic          accept;
  opcode_t       op;

  assign op = opcode_t'(cmd_opcode);

  // The response register doubles as a one-entry skid: a new command can be
  // taken whenever the held response is empty or leaving this cycle.
  assign cmd_rdy = !rsp_vld_q || rsp_rdy;
  assign accept  = cmd_vld && cmd_rdy;

  // Top of stack sits at level-1; the next free slot is at level. Both use
  // the low address bits only, since level == N never addresses the array
  // for writes (full) and level == 0 never reads (empty).
  assign mem_waddr = level_q[AW-1:0];
  assign mem_raddr = level_q[AW-1:0] - AW'(1);

  stk_ctrl_mem #(
    .W  (W),
    .N  (N),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdat  (cmd_dat),
    .raddr (mem_raddr),
    .rdat  (mem_rdat)
  );

  always_comb begin
    level_d   = level_q;
    rsp_vld_d = rsp_vld_q && !rsp_rdy;
    rsp_err_d = rsp_err_q;
    rsp_dat_d = rsp_dat_q;
    mem_we    = 1'b0;

    if (accept) begin
      rsp_vld_d = 1'b1;
      rsp_err_d = 1'b1;
      rsp_dat_d = '0;
      if (is_legal_opcode(op)) begin
        case (op)
          OPCODE_PUSH: begin
            if (!full_q) begin
              mem_we    = 1'b1;
              level_d   = level_q + LW'(1);
              rsp_err_d = 1'b0;
            end
          end
          OPCODE_POP: begin
            if (!empty_q) begin
              level_d   = level_q - LW'(1);
              rsp_err_d = 1'b0;
              rsp_dat_d = mem_rdat;
            end
          end
`ifdef STK_CTRL_PEEK_EN
          OPCODE_PEEK: begin
            if (!empty_q) begin
              rsp_err_d = 1'b0;
              rsp_dat_d = mem_rdat;
            end
          end
`endif
          default: begin
            rsp_err_d = 1'b1;
          end
        endcase
      end
    end

    // Status flags are registered alongside the level they describe.
    empty_d = (level_d == '0);
    full_d  = (level_d == LW'(N));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      level_q   <= level_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_err_q <= rsp_err_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  assign rsp_vld = rsp_vld_q;
  assign rsp_err = rsp_err_q;
  assign rsp_dat = rsp_dat_q;
  assign empty   = empty_q;
  assign full    = full_q;
  assign level   = level_q;

endmodule

// File: tb/tb_stk_ctrl.sv
// tb_stk_ctrl: directed bench for stk_ctrl with W=8, N=4.
module tb_stk_ctrl;
  import stk_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int LW = $clog2(N + 1);

  logic          clk;
  logic          arst;
  logic          cmd_vld;
  logic [1:0]    cmd_opcode;
  logic [W-1:0]  cmd_dat;
  logic          cmd_rdy;
  logic          rsp_vld;
  logic [W-1:0]  rsp_dat;
  logic          rsp_err;
  logic          rsp_rdy;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;

  int checks;
  int failures;

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_ILL0 = 2'b00;
  localparam logic [1:0] OP_11   = 2'b11;

  stk_ctrl #(
    .W (W),
    .N (N)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .cmd_vld    (cmd_vld),
    .cmd_opcode (cmd_opcode),
    .cmd_dat    (cmd_dat),
    .cmd_rdy    (cmd_rdy),
    .rsp_vld    (rsp_vld),
    .rsp_dat    (rsp_dat),
    .rsp_err    (rsp_err),
    .rsp_rdy    (rsp_rdy),
    .empty      (empty),
    .full       (full),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command, wait (bounded) for acceptance, and return #1 after
  // the accepting edge so the registered response can be sampled.
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] dat);
    int waited;
    waited     = 0;
    cmd_vld    = 1'b1;
    cmd_opcode = op;
    cmd_dat    = dat;
    #1;
    while (!cmd_rdy && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!cmd_rdy) check("cmd_rdy_timeout", 32'(cmd_rdy), 32'd1);
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic err, input logic [W-1:0] dat);
    check({tag, "_vld"}, 32'(rsp_vld), 32'd1);
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
    check({tag, "_dat"}, 32'(rsp_dat), 32'(dat));
  endtask

  initial begin
    logic [W-1:0] push_vals [4];
    logic [W-1:0] pop_vals  [4];
    checks     = 0;
    failures   = 0;
    arst       = 1'b1;
    cmd_vld    = 1'b0;
    cmd_opcode = '0;
    cmd_dat    = '0;
    rsp_rdy    = 1'b1;
    push_vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
    pop_vals   = '{8'h44, 8'h33, 8'h22, 8'h11};

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("rst_rsp_dat", 32'(rsp_dat), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_empty",   32'(empty),   32'd1);
    check("rst_full",    32'(full),    32'd0);
    check("rst_level",   32'(level),   32'd0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    #2;
    arst = 1'b0;
    @(posedge clk);
    #1;

    // Underflow straight after reset.
    do_cmd(OP_POP, 8'h00);
    expect_rsp("pop_empty", 1'b1, 8'h00);
    check("pop_empty_empty", 32'(empty), 32'd1);
    check("pop_empty_level", 32'(level), 32'd0);

    // Fill back-to-back.
    for (int i = 0; i < 4; i++) begin
      do_cmd(OP_PUSH, push_vals[i]);
      expect_rsp($sformatf("push%0d", i), 1'b0, 8'h00);
      check($sformatf("push%0d_level", i), 32'(level), 32'(i + 1));
    end
    check("fill_full", 32'(full), 32'd1);

    // Overflow.
    do_cmd(OP_PUSH, 8'h55);
    expect_rsp("push_full", 1'b1, 8'h00);
    check("push_full_level", 32'(level), 32'd4);
    check("push_full_full",  32'(full),  32'd1);

    // Drain in LIFO order.
    for (int i = 0; i < 4; i++) begin
      do_cmd(OP_POP, 8'h00);
      expect_rsp($sformatf("pop%0d", i), 1'b0, pop_vals[i]);
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_level", 32'(level), 32'd0);

    // Let the last response drain, then backpressure a PUSH.
    @(posedge clk);
    #1;
    check("idle_rsp_vld", 32'(rsp_vld), 32'd0);
    rsp_rdy = 1'b0;
    do_cmd(OP_PUSH, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_cmd_rdy", i), 32'(cmd_rdy), 32'd0);
      expect_rsp($sformatf("bp%0d", i), 1'b0, 8'h00);
      @(posedge clk);
      #1;
    end
    rsp_rdy    = 1'b1;
    cmd_vld    = 1'b1;
    cmd_opcode = OP_POP;
    #1;
    check("bp_release_cmd_rdy", 32'(cmd_rdy), 32'd1);
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    expect_rsp("bp_pop", 1'b0, 8'hAA);
    check("bp_pop_level", 32'(level), 32'd0);

    // Illegal opcode and 2'b11 behaviour.
    do_cmd(OP_PUSH, 8'h5A);
    check("p5a_level", 32'(level), 32'd1);
    do_cmd(OP_ILL0, 8'hFF);
    expect_rsp("op00", 1'b1, 8'h00);
    check("op00_level", 32'(level), 32'd1);
    do_cmd(OP_11, 8'hFF);
`ifdef STK_CTRL_PEEK_EN
    expect_rsp("peek", 1'b0, 8'h5A);
`else
    expect_rsp("op11", 1'b1, 8'h00);
`endif
    check("op11_level", 32'(level), 32'd1);
    do_cmd(OP_POP, 8'h00);
    expect_rsp("pop5a", 1'b0, 8'h5A);
    check("pop5a_empty", 32'(empty), 32'd1);

    // Reset in the middle of traffic with a held response.
    do_cmd(OP_PUSH, 8'h01);
    do_cmd(OP_PUSH, 8'h02);
    rsp_rdy = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_level", 32'(level), 32'd2);
    check("pre_rst_vld",   32'(rsp_vld), 32'd1);
    #2;
    arst = 1'b1;
    #1;
    check("mid_rst_vld",   32'(rsp_vld), 32'd0);
    check("mid_rst_level", 32'(level),   32'd0);
    check("mid_rst_empty", 32'(empty),   32'd1);
    #2;
    arst    = 1'b0;
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    do_cmd(OP_POP, 8'h00);
    expect_rsp("post_rst_pop", 1'b1, 8'h00);
    check("post_rst_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stk_ctrl.md
Name: stk_ctrl

Overview:
- Stack engine that sits directly downstream of the command source and consumes stk_pkg opcode_t commands (OPCODE_PUSH / OPCODE_POP).
- Stores data in an internal LIFO and returns exactly one registered response per accepted command: popped data or completion, plus an error flag.
- Uses a valid/ready handshake on both the command and response sides.

Parameters:
- W, 32, data width in bits.
- N, 16, stack depth in entries; must be >= 2.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- cmd_vld  in  1  command valid.
- cmd_opcode  in  2  stk_pkg::opcode_t.
- cmd_dat  in  W  push data; ignored for other opcodes.
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
- rsp_vld  out  1  response valid.
- rsp_dat  out  W  popped/peeked data; 0 for push and for errors.
- rsp_err  out  1  overflow, underflow or illegal opcode.
- rsp_rdy  in  1  response consumed when rsp_vld & rsp_rdy.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == N.
- level  out  $clog2(N+1)  current occupancy.

Behaviour:
- Reset (asynchronous, arst=1):
  - Pointer cleared to 0; rsp_vld=0, rsp_dat=0, rsp_err=0.
  - empty=1, full=0, level=0, cmd_rdy=1.
  - Memory contents are not reset.
  - Reset mid-operation discards any pending response and all stack contents.
- Handshake:
  - cmd_rdy = !rsp_vld | rsp_rdy (single-entry response skid, combinational ready).
  - Response valid 1 cycle after command acceptance; back-to-back throughput 1/cycle while rsp_rdy=1.
  - rsp_vld/rsp_dat/rsp_err hold stable while rsp_vld & !rsp_rdy.
- PUSH:
  - If !full: write mem[level] = cmd_dat, level+1; response rsp_err=0, rsp_dat=0.
  - If full: no write, level unchanged; response rsp_err=1, rsp_dat=0.
- POP:
  - If !empty: rsp_dat = mem[level-1], level-1, rsp_err=0.
  - If empty: level unchanged; rsp_err=1, rsp_dat=0.
- Illegal opcodes (2'b00; 2'b11 unless the optional feature is enabled): no state change; rsp_err=1, rsp_dat=0.
- Ordering:
  - Commands are processed strictly in acceptance order.
  - A PUSH followed by a POP on the next accepted cycle returns the pushed value; the write-then-read hazard is resolved by the registered write (no bypass needed, the memory is a flop array).
- Status: empty/full/level are registered and reflect state after all previously accepted commands.
- Level arithmetic: level never exceeds N nor goes below 0; error cases leave it unchanged.
- No internal FSM beyond the response-valid flop; the pointer is the only counter.

Optional Feature:
- Macro: STK_CTRL_PEEK_EN.
- Defined:
  - Opcode 2'b11 (OPCODE_PEEK, added to stk_pkg under the same macro) returns mem[level-1] with rsp_err=0 and level unchanged.
  - PEEK on empty gives rsp_err=1, rsp_dat=0.
- Undefined: 2'b11 is illegal and gives rsp_err=1, rsp_dat=0, no state change.

Decomposition:
- stk_pkg:
  - Add OPCODE_PEEK (guarded by STK_CTRL_PEEK_EN).
  - Add rsp_t struct {logic err; logic [W-1:0] dat} as a parameterless helper, width via module parameter.
  - Add function is_legal_opcode(opcode_t).
- One sub-module, stk_ctrl_mem: N x W flop array with a single write port and a single combinational read port, indexed by pointer.
- Pointer/level logic and the response register stay in stk_ctrl.

Test Plan (N=4, W=8):
- Reset then POP -> rsp_vld next cycle, rsp_err=1, rsp_dat=0x00, empty stays 1.
- PUSH 0x11,0x22,0x33,0x44 back-to-back with rsp_rdy=1 -> four responses err=0, full=1, level=4; fifth PUSH 0x55 -> rsp_err=1, level stays 4.
- Four POPs -> rsp_dat 0x44,0x33,0x22,0x11 in order, err=0; empty=1 afterwards.
- Backpressure: PUSH 0xAA, rsp_rdy=0 for 3 cycles -> cmd_rdy=0, response held (err=0, dat=0) until rsp_rdy=1; next command accepted that same cycle.
- Opcode 2'b00 -> err=1, level unchanged; opcode 2'b11 -> err=1 without STK_CTRL_PEEK_EN. With it, after PUSH 0x5A: rsp_dat=0x5A, err=0, level stays 1.
- Assert arst mid-stream after 2 pushes with a pending response -> rsp_vld=0, level=0, empty=1 immediately; a subsequent POP returns err=1.
